// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, IDLE/RUN/LAP/PAUSE
// state machine, count-tick prescaler, clear pulse and display freeze.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_DIV        = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       lap,
  output logic       tick,
  output logic       run,
  output logic       clr,
  output logic       freeze,
  output logic [1:0] state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  localparam int B_START = 0;
  localparam int B_STOP  = 1;
  localparam int B_LAP   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  logic [2:0]    btn;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    db;
  logic [2:0]    db_q;
  logic [2:0]    press;
  logic [DW-1:0] cnt [3];

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] pre;
  logic          counting;

  assign btn = {lap, stop, start};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = db & ~db_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (press[B_START]) state_d = RUN;
      end
      RUN: begin
        if (press[B_STOP])     state_d = PAUSE;
        else if (press[B_LAP]) state_d = LAP;
      end
      LAP: begin
        if (press[B_STOP])     state_d = PAUSE;
        else if (press[B_LAP]) state_d = RUN;
      end
      PAUSE: begin
        if (press[B_STOP])       state_d = IDLE;
        else if (press[B_START]) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      run     <= 1'b0;
      freeze  <= 1'b0;
      clr     <= 1'b0;
    end else begin
      state_q <= state_d;
      run     <= (state_d == RUN) || (state_d == LAP);
      freeze  <= (state_d == LAP);
      clr     <= (state_q == PAUSE) && (state_d == IDLE);
    end
  end

  assign state = state_q;

  // Count only while staying in RUN/LAP, so entry into PAUSE/IDLE never ticks
  assign counting = ((state_q == RUN) || (state_q == LAP)) &&
                    ((state_d == RUN) || (state_d == LAP));

  always_ff @(posedge clk) begin
    if (reset) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (counting) begin
        if (pre == PS_LAST) begin
          pre  <= '0;
          tick <= 1'b1;
        end else begin
          pre <= pre + 1'b1;
        end
      end else if (state_d == IDLE) begin
        pre <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with DEBOUNCE_CYCLES=4,
// TICK_DIV=5; expected values are hand-derived cycle counts.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       lap;
  logic       tick;
  logic       run;
  logic       clr;
  logic       freeze;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .lap(lap),
    .tick(tick),
    .run(run),
    .clr(clr),
    .freeze(freeze),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    lap   = 1'b0;
    step(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (state !== 2'd0 || run !== 1'b0 || freeze !== 1'b0 ||
        clr !== 1'b0 || tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got st=%0d run=%0b frz=%0b clr=%0b tick=%0b need 0 0 0 0 0",
               state, run, freeze, clr, tick);
    end
  endtask

  task automatic test_start_hold();
    int exp_t;
    do_reset();
    start = 1'b1;
    step(6);
    n_cmp++;
    if (state !== 2'd0) begin
      n_bad++;
      $display("FAIL start_early: state=%0d need 0", state);
    end
    step();
    n_cmp++;
    if (state !== 2'd1 || run !== 1'b1) begin
      n_bad++;
      $display("FAIL start_latency: state=%0d run=%0b need 1 1", state, run);
    end
    for (int k = 1; k <= 15; k++) begin
      step();
      exp_t = (k % 5 == 0) ? 1 : 0;
      n_cmp++;
      if (tick !== exp_t[0]) begin
        n_bad++;
        $display("FAIL tick_cadence k=%0d: tick=%0b need %0b", k, tick, exp_t[0]);
      end
    end
    n_cmp++;
    if (state !== 2'd1) begin
      n_bad++;
      $display("FAIL hold_single_press: state=%0d need 1", state);
    end
    start = 1'b0;
  endtask

  task automatic test_glitch();
    do_reset();
    start = 1'b1;
    step(3);
    start = 1'b0;
    step(12);
    n_cmp++;
    if (state !== 2'd0) begin
      n_bad++;
      $display("FAIL glitch_reject: state=%0d need 0", state);
    end
    start = 1'b1;
    step(5);
    start = 1'b0;
    step(2);
    n_cmp++;
    if (state !== 2'd1) begin
      n_bad++;
      $display("FAIL pulse_accept: state=%0d need 1", state);
    end
  endtask

  task automatic test_pause_resume();
    int nt;
    int exp_t;
    do_reset();
    start = 1'b1;
    step(7);
    start = 1'b0;
    step();
    stop = 1'b1;
    step(7);
    n_cmp++;
    if (state !== 2'd3 || run !== 1'b0 || tick !== 1'b0) begin
      n_bad++;
      $display("FAIL pause_entry: st=%0d run=%0b tick=%0b need 3 0 0", state, run, tick);
    end
    stop = 1'b0;
    nt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (tick === 1'b1) nt++;
    end
    n_cmp++;
    if (nt !== 0 || state !== 2'd3) begin
      n_bad++;
      $display("FAIL pause_hold: ticks=%0d st=%0d need 0 3", nt, state);
    end
    start = 1'b1;
    step(7);
    start = 1'b0;
    n_cmp++;
    if (state !== 2'd1 || run !== 1'b1) begin
      n_bad++;
      $display("FAIL resume: st=%0d run=%0b need 1 1", state, run);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_t = (k == 3 || k == 8) ? 1 : 0;
      n_cmp++;
      if (tick !== exp_t[0]) begin
        n_bad++;
        $display("FAIL resume_tick k=%0d: tick=%0b need %0b", k, tick, exp_t[0]);
      end
    end
  endtask

  task automatic test_lap();
    int nt;
    do_reset();
    start = 1'b1;
    step(7);
    start = 1'b0;
    lap   = 1'b1;
    step(7);
    lap = 1'b0;
    n_cmp++;
    if (state !== 2'd2 || freeze !== 1'b1 || run !== 1'b1) begin
      n_bad++;
      $display("FAIL lap_entry: st=%0d frz=%0b run=%0b need 2 1 1", state, freeze, run);
    end
    nt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (tick === 1'b1) nt++;
    end
    n_cmp++;
    if (nt !== 2) begin
      n_bad++;
      $display("FAIL lap_ticks: ticks=%0d need 2", nt);
    end
    lap = 1'b1;
    step(7);
    lap = 1'b0;
    n_cmp++;
    if (state !== 2'd1 || freeze !== 1'b0) begin
      n_bad++;
      $display("FAIL lap_exit: st=%0d frz=%0b need 1 0", state, freeze);
    end
    step();
    n_cmp++;
    if (tick !== 1'b1) begin
      n_bad++;
      $display("FAIL lap_prescale_kept: tick=%0b need 1", tick);
    end
    step(6);
    lap = 1'b1;
    step(7);
    lap  = 1'b0;
    stop = 1'b1;
    step(7);
    stop = 1'b0;
    n_cmp++;
    if (state !== 2'd3 || freeze !== 1'b0 || run !== 1'b0 || tick !== 1'b0) begin
      n_bad++;
      $display("FAIL lap_to_pause: st=%0d frz=%0b run=%0b tick=%0b need 3 0 0 0",
               state, freeze, run, tick);
    end
  endtask

  task automatic test_clr();
    int exp_t;
    do_reset();
    start = 1'b1;
    step(7);
    start = 1'b0;
    step(7);
    stop = 1'b1;
    step(7);
    stop = 1'b0;
    step(7);
    stop = 1'b1;
    step(6);
    n_cmp++;
    if (state !== 2'd3 || clr !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_early: st=%0d clr=%0b need 3 0", state, clr);
    end
    step();
    n_cmp++;
    if (state !== 2'd0 || clr !== 1'b1 || run !== 1'b0 || tick !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_pulse: st=%0d clr=%0b run=%0b tick=%0b need 0 1 0 0",
               state, clr, run, tick);
    end
    step();
    stop = 1'b0;
    n_cmp++;
    if (clr !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_width: clr=%0b need 0", clr);
    end
    step(7);
    stop = 1'b1;
    step(8);
    stop = 1'b0;
    step(7);
    lap = 1'b1;
    step(8);
    lap = 1'b0;
    n_cmp++;
    if (state !== 2'd0 || clr !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ignore: st=%0d clr=%0b need 0 0", state, clr);
    end
    step(7);
    start = 1'b1;
    step(7);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_t = (k == 5) ? 1 : 0;
      n_cmp++;
      if (tick !== exp_t[0]) begin
        n_bad++;
        $display("FAIL prescale_zeroed k=%0d: tick=%0b need %0b", k, tick, exp_t[0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    start = 1'b1;
    step(7);
    start = 1'b0;
    step(7);
    start = 1'b1;
    stop  = 1'b1;
    lap   = 1'b1;
    step(7);
    n_cmp++;
    if (state !== 2'd3) begin
      n_bad++;
      $display("FAIL simul_run: st=%0d need 3", state);
    end
    step();
    n_cmp++;
    if (state !== 2'd3) begin
      n_bad++;
      $display("FAIL simul_single: st=%0d need 3", state);
    end
    start = 1'b0;
    stop  = 1'b0;
    lap   = 1'b0;
    step(8);
    start = 1'b1;
    stop  = 1'b1;
    step(7);
    n_cmp++;
    if (state !== 2'd0 || clr !== 1'b1) begin
      n_bad++;
      $display("FAIL simul_pause: st=%0d clr=%0b need 0 1", state, clr);
    end
    start = 1'b0;
    stop  = 1'b0;
    step(8);
    start = 1'b1;
    step(7);
    start = 1'b0;
    step(4);
    reset = 1'b1;
    step();
    n_cmp++;
    if (state !== 2'd0 || run !== 1'b0 || freeze !== 1'b0 ||
        clr !== 1'b0 || tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_run: st=%0d run=%0b frz=%0b clr=%0b tick=%0b need 0 0 0 0 0",
               state, run, freeze, clr, tick);
    end
    reset = 1'b0;
  endtask

  task automatic test_held_reset();
    reset = 1'b1;
    start = 1'b1;
    stop  = 1'b0;
    lap   = 1'b0;
    step(3);
    reset = 1'b0;
    step(6);
    n_cmp++;
    if (state !== 2'd0) begin
      n_bad++;
      $display("FAIL held_early: st=%0d need 0", state);
    end
    step();
    n_cmp++;
    if (state !== 2'd1) begin
      n_bad++;
      $display("FAIL held_accept: st=%0d need 1", state);
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    lap   = 1'b0;
    test_reset();
    test_start_hold();
    test_glitch();
    test_pause_resume();
    test_lap();
    test_clr();
    test_simultaneous();
    test_held_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch datapath. It debounces the raw start, stop and lap buttons, runs the IDLE/RUN/LAP/PAUSE state machine and generates the count-enable tick. It also produces the clear pulse and the display-freeze signal. It sits between the board buttons and the BCD digit counter, whose six digits feed the seven-segment controller.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1000000: number of consecutive clock edges a synchronized input must hold its new level before the debounced level changes. Minimum 2.
- TICK_DIV, default 1000000: clock cycles per count tick (10 ms at 100 MHz). Minimum 2.

Ports:
- clk  in  1  system clock; the block has one clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  raw start button, asynchronous, active-high.
- stop  in  1  raw stop button, asynchronous, active-high.
- lap  in  1  raw lap button, asynchronous, active-high.
- tick  out  1  one-cycle pulse; the digit counter advances by one on each pulse.
- run  out  1  high in RUN and LAP.
- clr  out  1  one-cycle pulse that zeroes the digit counter.
- freeze  out  1  high in LAP; the display holds its last digits while this is high.
- state  out  2  current state: IDLE=0, RUN=1, LAP=2, PAUSE=3.

## Operation
Input conditioning:
- Each button passes through a 2-FF synchronizer (sync1, sync2).
- Debounce, per button: a counter increments on every edge where sync2 differs from the debounced level db, and clears to 0 on any edge where they match.
- On the edge where a mismatch occurs with count == DEBOUNCE_CYCLES-1, db takes the value of sync2 and the counter clears.
- Press pulse = db & ~db_q, where db_q is db delayed one cycle. It is high for exactly one cycle per debounced rising edge.
- A release does nothing.

State machine:
- Priority when press pulses coincide: stop > start > lap. Only one transition is taken per cycle.
- IDLE: start → RUN. stop and lap are ignored.
- RUN: stop → PAUSE. lap → LAP.
- LAP: lap → RUN. stop → PAUSE. start is ignored.
- PAUSE: start → RUN (resume without clearing). stop → IDLE, and clr pulses. lap is ignored.

Outputs:
- run, freeze, state and clr are registered and follow the state register.
- clr is high for exactly the first cycle in which state = IDLE after PAUSE → IDLE.

Tick prescaler:
- Width is $clog2(TICK_DIV).
- In RUN and LAP the prescaler increments; on the edge where it equals TICK_DIV-1 it wraps to 0 and tick is registered high for one cycle.
- In PAUSE the prescaler holds its value, so the partial interval is kept across the pause.
- In IDLE it is held at 0.
- RUN ↔ LAP transitions do not disturb the prescaler.

Reset:
- While reset is high: state=IDLE, run=0, freeze=0, clr=0, tick=0, prescaler=0, all sync/db/db_q flops=0, all debounce counters=0.
- Reset in any state, including mid-debounce and mid-interval, aborts everything.
- A button still held when reset is released is accepted as a new press after full debounce.

## Timing
- Button latency: if raw start is sampled high at edge 0 and stays high, then:
  - db rises at edge DEBOUNCE_CYCLES+1;
  - the press pulse is high during the following cycle;
  - state and run change at edge DEBOUNCE_CYCLES+2.
- A glitch shorter than DEBOUNCE_CYCLES+1 cycles produces no press.
- First tick after IDLE → RUN occurs TICK_DIV cycles after the edge at which state became RUN.
- After that, one tick every TICK_DIV cycles while in RUN or LAP.
- PAUSE → RUN resume: the first tick arrives after the remaining TICK_DIV − held_count cycles.
- tick and clr never assert in the same cycle.
- tick never asserts in IDLE or PAUSE, or in the cycle of entry into either state.
- Holding a button produces a single press. A new press requires a debounced release followed by a debounced press.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, TICK_DIV=5.

1. Reset, then hold start high → state=1 and run=1 at edge 6. Ticks at 5, 10, 15 cycles after that edge.
2. Start pulse high for 4 cycles, then low → no state change. A 5-cycle pulse → RUN.
3. RUN, press stop when prescaler=2 → PAUSE, no ticks. Press start → first tick 3 cycles after state=1.
4. RUN, press lap → state=2, freeze=1, ticks continue. Press lap again → state=1, freeze=0. Press lap, then stop → state=3, freeze=0.
5. PAUSE, press stop → state=0, clr high exactly 1 cycle, prescaler=0. In IDLE, presses of stop and lap cause no change.
6. In RUN, start, stop and lap debounced simultaneously → PAUSE only. Assert reset mid-RUN → all outputs 0 and state=0 on the next edge.
